botao_condicionador: RTL

- Upstream conditioner for the `semaforo` pedestrian button input `bt`.
- Takes the raw, asynchronous, bouncing push-button line and runs it through a synchronizer and a debounce FSM.
- Emits exactly one clean single-cycle `bt_pulse` per physical press, plus a sticky `bt_pending` request that holds until `semaforo` acknowledges it.
- Also keeps a saturating press counter for observability.

---
 rtl/botao_condicionador_if.sv | 37 +++
 rtl/botao_condicionador.sv | 134 +++++++++++++
 2 files changed

// File: rtl/botao_condicionador_if.sv
// botao_condicionador_if
//   Groups the button-conditioner signals exchanged with the surrounding logic.
//   master : drives the raw button line and the acknowledge (semaforo / bench side)
//   slave  : the conditioner itself
//   Signals:
//     bt_raw      raw, asynchronous, bouncing button line
//     ack         request acknowledge, clears bt_pending
//     bt_pulse    one-cycle pulse per accepted press
//     bt_pending  sticky request flag
//     bt_level    debounced button level
//     press_count saturating count of accepted presses
interface botao_condicionador_if;
    logic       bt_raw;
    logic       ack;
    logic       bt_pulse;
    logic       bt_pending;
    logic       bt_level;
    logic [7:0] press_count;

    modport master (
        output bt_raw,
        output ack,
        input  bt_pulse,
        input  bt_pending,
        input  bt_level,
        input  press_count
    );

    modport slave (
        input  bt_raw,
        input  ack,
        output bt_pulse,
        output bt_pending,
        output bt_level,
        output press_count
    );
endinterface

// File: rtl/botao_condicionador.sv
// botao_condicionador
//   Conditions the pedestrian push-button for semaforo: synchronizes the raw
//   line, debounces it with a four-state FSM, and emits one clean pulse per
//   physical press plus a sticky request held until acknowledged. A saturating
//   press counter is kept for observability.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bif  slave side of botao_condicionador_if (bt_raw, ack in;
//          bt_pulse, bt_pending, bt_level, press_count out)
//   Parameters:
//     SYNC_STAGES      synchronizer depth on bt_raw (2..4)
//     DEBOUNCE_CYCLES  consecutive equal samples needed to accept a change (2..255)
module botao_condicionador #(
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter logic [7:0]       DEBOUNCE_CYCLES = 8'd4
) (
    input  logic                 clk,
    input  logic                 rst,
    botao_condicionador_if.slave bif
);

    typedef enum logic [1:0] {
        SOLTO,
        CONFIRMA_APERTO,
        PRESSIONADO,
        CONFIRMA_SOLTURA
    } estado_t;

    localparam logic [7:0] CNT_MAX = DEBOUNCE_CYCLES - 8'd1;

    estado_t                estado;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [7:0]             cnt;
    logic                   pulse_r;
    logic                   pending_r;
    logic                   level_r;
    logic [7:0]             count_r;
    logic                   pulse_set;

    // Only the last synchronizer flop is ever looked at by the FSM.
    assign s = sync[SYNC_STAGES-1];

    // Edge at which a press is accepted; pending and counter update on it too.
    assign pulse_set = (estado == CONFIRMA_APERTO) && s && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bif.bt_raw};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado  <= SOLTO;
            cnt     <= '0;
            pulse_r <= 1'b0;
            level_r <= 1'b0;
        end else begin
            pulse_r <= 1'b0;
            case (estado)
                SOLTO: begin
                    if (s) begin
                        estado <= CONFIRMA_APERTO;
                        cnt    <= 8'd1;
                    end
                end
                CONFIRMA_APERTO: begin
                    if (!s) begin
                        estado <= SOLTO;
                        cnt    <= '0;
                    end else if (cnt == CNT_MAX) begin
                        estado  <= PRESSIONADO;
                        cnt     <= '0;
                        pulse_r <= 1'b1;
                        level_r <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PRESSIONADO: begin
                    if (!s) begin
                        estado <= CONFIRMA_SOLTURA;
                        cnt    <= 8'd1;
                    end
                end
                CONFIRMA_SOLTURA: begin
                    // A high sample here is release bounce: back to held, no pulse.
                    if (s) begin
                        estado <= PRESSIONADO;
                        cnt    <= '0;
                    end else if (cnt == CNT_MAX) begin
                        estado  <= SOLTO;
                        cnt     <= '0;
                        level_r <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    estado  <= SOLTO;
                    cnt     <= '0;
                    level_r <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= 1'b0;
            count_r   <= '0;
        end else begin
            // A new request wins over a simultaneous acknowledge.
            if (pulse_set) begin
                pending_r <= 1'b1;
            end else if (bif.ack) begin
                pending_r <= 1'b0;
            end
            if (pulse_set && (count_r != 8'hFF)) begin
                count_r <= count_r + 8'd1;
            end
        end
    end

    assign bif.bt_pulse    = pulse_r;
    assign bif.bt_pending  = pending_r;
    assign bif.bt_level    = level_r;
    assign bif.press_count = count_r;

endmodule
